// File: rtl/booth_pkg.sv
// Shared definitions for the Booth multiplier datapath and its downstream stages.
package booth_pkg;

  localparam int WIDTH_DEF = 4;

  typedef enum logic {
    S_ACC = 1'b0,
    S_OUT = 1'b1
  } state_e;

  // Accumulator width: a full signed product plus guard bits.
  function automatic int acc_width(input int width, input int acc_ext);
    return 2 * width + acc_ext;
  endfunction

endpackage

// File: rtl/booth_accum_if.sv
// Valid/ready bus that carries one accumulated burst sum to its consumer.
interface booth_accum_if #(
  parameter int AW = 16
);
  logic          acc_valid;
  logic          acc_ready;
  logic [AW-1:0] acc_out;
  logic          acc_sat;

  modport master (output acc_valid, output acc_out, output acc_sat, input acc_ready);
  modport slave  (input acc_valid, input acc_out, input acc_sat, output acc_ready);
endinterface

// File: rtl/booth_sat_add.sv
// Signed saturating adder: clamps to the AW-bit range and flags the overflow.
module booth_sat_add #(
  parameter int AW = 16
) (
  input  logic signed [AW-1:0] a,
  input  logic signed [AW-1:0] b,
  output logic signed [AW-1:0] sum,
  output logic                 ovf
);

  logic signed [AW:0] wide;

  // NOTE: every output is assigned on every path through the block, so no latch is inferred.
  always_comb begin
    wide = {a[AW-1], a} + {b[AW-1], b};
    ovf  = wide[AW] != wide[AW-1];
    if (!ovf)          sum = wide[AW-1:0];
    else if (wide[AW]) sum = {1'b1, {(AW-1){1'b0}}};
    else               sum = {1'b0, {(AW-1){1'b1}}};
  end

endmodule

// File: rtl/booth_accum.sv
// Sums BURST signed products, each taken on a rising edge of done_in, and hands
// the saturated sum downstream; a one-entry skid covers a product that arrives while the sum waits.
module booth_accum
  import booth_pkg::*;
#(
  parameter int WIDTH   = WIDTH_DEF,
  parameter int ACC_EXT = 8,
  parameter int BURST   = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               done_in,
  input  logic [2*WIDTH-1:0] product_in,
  input  logic               clear,
  booth_accum_if.master      acc_if,
  output logic               drop_err
);

  localparam int AW = acc_width(WIDTH, ACC_EXT);
  localparam int CW = $clog2(BURST + 1);

  state_e               state_q;
  logic                 done_q;
  logic [CW-1:0]        cnt_q;
  logic signed [AW-1:0] acc_q;
  logic                 sat_q;
  logic [2*WIDTH-1:0]   skid_q;
  logic                 skid_vld_q;
  logic                 valid_q;
  logic signed [AW-1:0] out_q;
  logic                 osat_q;
  logic                 drop_q;

  logic                 take;
  logic signed [AW-1:0] sext_prod;
  logic signed [AW-1:0] seed;
  logic signed [AW-1:0] add_sum;
  logic                 add_ovf;

  assign take      = done_in & ~done_q;
  assign sext_prod = AW'($signed(product_in));
  // A waiting skid entry is older than any product arriving now, so it seeds first.
  assign seed      = skid_vld_q ? AW'($signed(skid_q)) : sext_prod;

  booth_sat_add #(.AW(AW)) u_add (
    .a   (acc_q),
    .b   (sext_prod),
    .sum (add_sum),
    .ovf (add_ovf)
  );

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_ACC;
      done_q     <= 1'b0;
      cnt_q      <= '0;
      acc_q      <= '0;
      sat_q      <= 1'b0;
      skid_q     <= '0;
      skid_vld_q <= 1'b0;
      valid_q    <= 1'b0;
      out_q      <= '0;
      osat_q     <= 1'b0;
      drop_q     <= 1'b0;
    end else begin
      done_q <= done_in;
      if (clear) begin
        state_q    <= S_ACC;
        cnt_q      <= '0;
        acc_q      <= '0;
        sat_q      <= 1'b0;
        skid_q     <= '0;
        skid_vld_q <= 1'b0;
        valid_q    <= 1'b0;
        osat_q     <= 1'b0;
        drop_q     <= 1'b0;
      end else begin
        unique case (state_q)
          S_ACC: begin
            if (take) begin
              acc_q <= add_sum;
              sat_q <= sat_q | add_ovf;
              if (cnt_q == CW'(BURST - 1)) begin
                cnt_q   <= '0;
                out_q   <= add_sum;
                osat_q  <= sat_q | add_ovf;
                valid_q <= 1'b1;
                state_q <= S_OUT;
              end else begin
                cnt_q <= cnt_q + CW'(1);
              end
            end
          end
          S_OUT: begin
            if (acc_if.acc_ready) begin
              sat_q      <= 1'b0;
              skid_vld_q <= skid_vld_q & take;
              if (skid_vld_q && take) skid_q <= product_in;
              if (skid_vld_q || take) begin
                acc_q <= seed;
                if (BURST == 1) begin
                  // A single product completes the next burst immediately.
                  cnt_q  <= '0;
                  out_q  <= seed;
                  osat_q <= 1'b0;
                end else begin
                  cnt_q   <= CW'(1);
                  valid_q <= 1'b0;
                  state_q <= S_ACC;
                end
              end else begin
                acc_q   <= '0;
                cnt_q   <= '0;
                valid_q <= 1'b0;
                state_q <= S_ACC;
              end
            end else if (take) begin
              if (!skid_vld_q) begin
                skid_q     <= product_in;
                skid_vld_q <= 1'b1;
              end else begin
                drop_q <= 1'b1;
              end
            end
          end
          default: state_q <= S_ACC;
        endcase
      end
    end
  end

  assign acc_if.acc_valid = valid_q;
  assign acc_if.acc_out   = out_q;
  assign acc_if.acc_sat   = osat_q;
  assign drop_err         = drop_q;

endmodule

// File: tb/tb_booth_accum.sv
// Drives three configurations of booth_accum with the same stimulus and compares
// each against a queue-based reference model every cycle.
module tb_booth_accum;

  typedef logic signed [63:0] val_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       done_in = 1'b0;
  logic [7:0] product_in = '0;
  logic       clear = 1'b0;
  logic       ready = 1'b0;
  logic       drop0, drop1, drop2;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  // DUT 0: WIDTH=4 ACC_EXT=8 BURST=4; DUT 1: BURST=1; DUT 2: ACC_EXT=0 (8-bit accumulator).
  booth_accum_if #(.AW(16)) if0 ();
  booth_accum_if #(.AW(16)) if1 ();
  booth_accum_if #(.AW(8))  if2 ();

  assign if0.acc_ready = ready;
  assign if1.acc_ready = ready;
  assign if2.acc_ready = ready;

  booth_accum #(.WIDTH(4), .ACC_EXT(8), .BURST(4)) dut0 (
    .clk(clk), .rst(rst), .done_in(done_in), .product_in(product_in),
    .clear(clear), .acc_if(if0), .drop_err(drop0));
  booth_accum #(.WIDTH(4), .ACC_EXT(8), .BURST(1)) dut1 (
    .clk(clk), .rst(rst), .done_in(done_in), .product_in(product_in),
    .clear(clear), .acc_if(if1), .drop_err(drop1));
  booth_accum #(.WIDTH(4), .ACC_EXT(0), .BURST(4)) dut2 (
    .clk(clk), .rst(rst), .done_in(done_in), .product_in(product_in),
    .clear(clear), .acc_if(if2), .drop_err(drop2));

  // Reference model: running sum, products counted, waiting queue of at most one entry.
  int    cfg_aw[3]    = '{16, 16, 8};
  int    cfg_burst[3] = '{4, 1, 4};
  longint m_acc[3];
  int     m_cnt[3];
  bit     m_sat[3];
  bit     m_valid[3];
  longint m_out[3];
  bit     m_osat[3];
  bit     m_drop[3];
  longint m_pend[3][$];
  bit     prev_done;

  function automatic longint clamp_add(input longint a, input longint b, input int aw,
                                       output bit ovf);
    longint hi, lo, s;
    hi  = (longint'(1) <<< (aw - 1)) - 1;
    lo  = -hi - 1;
    s   = a + b;
    ovf = (s > hi) || (s < lo);
    if (s > hi) s = hi;
    if (s < lo) s = lo;
    return s;
  endfunction

  function automatic void model_reset();
    for (int k = 0; k < 3; k++) begin
      m_acc[k] = 0; m_cnt[k] = 0; m_sat[k] = 0; m_valid[k] = 0;
      m_out[k] = 0; m_osat[k] = 0; m_drop[k] = 0;
      m_pend[k].delete();
    end
    prev_done = 1'b0;
  endfunction

  function automatic void model_step(input int k, input bit take, input longint p,
                                     input bit rdy, input bit clr);
    bit o;
    if (clr) begin
      m_acc[k] = 0; m_cnt[k] = 0; m_sat[k] = 0; m_valid[k] = 0;
      m_osat[k] = 0; m_drop[k] = 0;
      m_pend[k].delete();
      return;
    end
    if (!m_valid[k]) begin
      if (take) begin
        m_acc[k] = clamp_add(m_acc[k], p, cfg_aw[k], o);
        m_sat[k] = m_sat[k] | o;
        m_cnt[k]++;
        if (m_cnt[k] == cfg_burst[k]) begin
          m_valid[k] = 1; m_out[k] = m_acc[k]; m_osat[k] = m_sat[k];
        end
      end
    end else if (rdy) begin
      m_acc[k] = 0; m_cnt[k] = 0; m_sat[k] = 0; m_valid[k] = 0;
      if (take) m_pend[k].push_back(p);
      if (m_pend[k].size() > 0) begin
        m_acc[k] = m_pend[k].pop_front();
        m_cnt[k] = 1;
        if (m_cnt[k] == cfg_burst[k]) begin
          m_valid[k] = 1; m_out[k] = m_acc[k]; m_osat[k] = 0;
        end
      end
    end else if (take) begin
      if (m_pend[k].size() < 1) m_pend[k].push_back(p);
      else m_drop[k] = 1;
    end
  endfunction

  task automatic check(input string tag, input val_t obs, input val_t exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_one(input int k, input logic v, input val_t o, input logic s,
                           input logic d, input bit force_all);
    check($sformatf("acc_valid[%0d]", k), val_t'(v), val_t'(m_valid[k]));
    check($sformatf("drop_err[%0d]", k), val_t'(d), val_t'(m_drop[k]));
    if (m_valid[k] || force_all) begin
      check($sformatf("acc_out[%0d]", k), o, val_t'(m_out[k]));
      check($sformatf("acc_sat[%0d]", k), val_t'(s), val_t'(m_osat[k]));
    end
  endtask

  task automatic check_all(input bit force_all);
    check_one(0, if0.acc_valid, val_t'($signed(if0.acc_out)), if0.acc_sat, drop0, force_all);
    check_one(1, if1.acc_valid, val_t'($signed(if1.acc_out)), if1.acc_sat, drop1, force_all);
    check_one(2, if2.acc_valid, val_t'($signed(if2.acc_out)), if2.acc_sat, drop2, force_all);
  endtask

  // One clock: drive at the falling edge, update the model at the rising edge, compare at the next falling edge.
  task automatic tick(input bit d, input logic [7:0] pr, input bit c);
    bit take;
    done_in = d; product_in = pr; clear = c;
    @(posedge clk);
    take = d && !prev_done;
    prev_done = d;
    for (int k = 0; k < 3; k++) model_step(k, take, longint'($signed(pr)), ready, c);
    @(negedge clk);
    check_all(1'b0);
  endtask

  task automatic send(input logic [7:0] pr, input int hold, input int gap);
    for (int i = 0; i < hold; i++) tick(1'b1, pr, 1'b0);
    for (int i = 0; i < gap; i++)  tick(1'b0, pr, 1'b0);
  endtask

  task automatic do_reset();
    rst = 1'b0; done_in = 1'b0; clear = 1'b0;
    model_reset();
    #1;
    check_all(1'b1);
    repeat (2) @(negedge clk);
    check_all(1'b1);
    rst = 1'b1;
  endtask

  initial begin
    logic [7:0] rp;
    @(negedge clk);
    do_reset();

    // Basic burst 3, -5, 7, 2 with the consumer always ready.
    ready = 1'b1;
    send(8'd3, 3, 7); send(8'hFB, 3, 7); send(8'd7, 3, 7); send(8'd2, 3, 7);

    // A level-high done yields one take only.
    send(8'd6, 5, 4);
    tick(1'b0, 8'd0, 1'b1);

    // Saturation in the narrow accumulator: 4 x 64 then 4 x -56.
    for (int i = 0; i < 4; i++) send(8'h40, 2, 2);
    tick(1'b0, 8'd0, 1'b1);
    for (int i = 0; i < 4; i++) send(8'hC8, 2, 2);
    tick(1'b0, 8'd0, 1'b1);

    // Consumer stalls: sum 10 waits, 4 goes to the skid, 9 is dropped.
    ready = 1'b0;
    send(8'd1, 1, 1); send(8'd2, 1, 1); send(8'd3, 1, 1); send(8'd4, 1, 3);
    send(8'd4, 2, 2); send(8'd9, 2, 2);
    ready = 1'b1;
    tick(1'b0, 8'd0, 1'b0);
    send(8'd1, 1, 1); send(8'd1, 1, 1); send(8'd1, 1, 3);
    tick(1'b0, 8'd0, 1'b1);

    // Take coincident with the handshake: sum 20 accepted, -3 seeds the next burst.
    ready = 1'b0;
    for (int i = 0; i < 4; i++) send(8'd5, 1, 1);
    tick(1'b0, 8'd0, 1'b0);
    ready = 1'b1;
    send(8'hFD, 1, 1);
    send(8'd2, 1, 1); send(8'd2, 1, 1); send(8'd2, 1, 3);
    tick(1'b0, 8'd0, 1'b1);

    // Reset in the middle of a burst, then a clean burst of ones.
    send(8'd7, 1, 1); send(8'd7, 1, 1);
    do_reset();
    for (int i = 0; i < 4; i++) send(8'd1, 1, 1);
    tick(1'b0, 8'd0, 1'b0);

    // Clear together with a take discards that take and the flags.
    ready = 1'b0;
    send(8'd3, 1, 1); send(8'd3, 1, 1);
    tick(1'b1, 8'd5, 1'b1);
    tick(1'b1, 8'd5, 1'b0);
    tick(1'b0, 8'd5, 1'b0);
    ready = 1'b1;
    for (int i = 0; i < 4; i++) send(8'd2, 1, 1);

    // Randomised traffic: bursty done pulses, stalls and occasional clears.
    rp = 8'd0;
    for (int i = 0; i < 600; i++) begin
      ready = ($urandom_range(0, 3) != 0);
      if (done_in) begin
        tick(($urandom_range(0, 1) == 1), rp, ($urandom_range(0, 79) == 0));
      end else begin
        if ($urandom_range(0, 2) == 0) begin
          rp = 8'($urandom_range(0, 255));
          tick(1'b1, rp, ($urandom_range(0, 79) == 0));
        end else begin
          tick(1'b0, rp, ($urandom_range(0, 79) == 0));
        end
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
